// File: rtl/nz_mask_builder_pkg.sv
// Shared constants, brick record and output-slot state encoding for the
// zero-skip mask builder.
package nz_mask_builder_pkg;

    localparam int N         = 16;
    localparam int NEURON_W  = 16;
    localparam int ADDR_SIZE = 16;

    typedef struct packed {
        logic [N-1:0]         mask;
        logic [ADDR_SIZE-1:0] base_addr;
    } brick_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/nz_out_slot.sv
// One-entry valid/ready output register. A load may coincide with a drain so
// consecutive bricks leave without a bubble.
module nz_out_slot
    import nz_mask_builder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] data_o
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    // Next-state and data capture for the output slot
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else if (out_ready_i) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
        if (load_i) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = (state_q == SLOT_FULL);
    assign data_o      = data_q;

endmodule

// File: rtl/nz_mask_builder.sv
// Groups incoming neurons into bricks of N, builds the non-zero mask and tags
// each brick with its SRAM base address for the zero-skip compressor.
module nz_mask_builder
    import nz_mask_builder_pkg::*;
#(
    parameter int N         = nz_mask_builder_pkg::N,
    parameter int NEURON_W  = nz_mask_builder_pkg::NEURON_W,
    parameter int ADDR_SIZE = nz_mask_builder_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEURON_W-1:0]  in_neuron,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_mask,
    output logic [ADDR_SIZE-1:0] out_base_addr
);

    localparam int IDX_W = $clog2(N);

    // Bits 0..idx set; clears anything above the last neuron of a short brick.
    function automatic logic [N-1:0] low_mask(input logic [IDX_W-1:0] idx);
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (i <= int'(idx)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N-1:0]         acc_q, acc_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;

    logic                 in_ready_s;
    logic                 stall_last_s;
    logic                 accept_s;
    logic                 complete_s;
    logic [N-1:0]         bit_s;
    logic [N-1:0]         mask_s;
    logic                 slot_valid_s;
    logic [N+ADDR_SIZE-1:0] slot_data_s;

    // A stalled slot blocks only the accept that would complete a brick.
    assign stall_last_s = in_last & in_valid & slot_valid_s & ~out_ready;
    assign in_ready_s   = (~slot_valid_s | out_ready | (idx_q != IDX_W'(N - 1))) & ~stall_last_s;
    assign accept_s     = in_valid & in_ready_s & ~start;
    assign complete_s   = accept_s & ((idx_q == IDX_W'(N - 1)) | in_last);
    assign bit_s        = {{(N-1){1'b0}}, (|in_neuron)} << idx_q;
    assign mask_s       = (acc_q | bit_s) & low_mask(idx_q);

    // Accumulator, index and address next-state; start wins over accept
    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        addr_d = addr_q;
        if (start) begin
            idx_d  = {IDX_W{1'b0}};
            acc_d  = {N{1'b0}};
            addr_d = start_addr;
        end else if (complete_s) begin
            idx_d  = {IDX_W{1'b0}};
            acc_d  = {N{1'b0}};
            addr_d = addr_q + ADDR_SIZE'(N);
        end else if (accept_s) begin
            idx_d  = idx_q + IDX_W'(1);
            acc_d  = acc_q | bit_s;
            addr_d = addr_q;
        end else begin
            idx_d  = idx_q;
            acc_d  = acc_q;
            addr_d = addr_q;
        end
    end

    // Brick assembly registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= {IDX_W{1'b0}};
            acc_q  <= {N{1'b0}};
            addr_q <= {ADDR_SIZE{1'b0}};
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            addr_q <= addr_d;
        end
    end

    nz_out_slot #(
        .W (N + ADDR_SIZE)
    ) u_out_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (complete_s),
        .data_i      ({mask_s, addr_q}),
        .out_ready_i (out_ready),
        .out_valid_o (slot_valid_s),
        .data_o      (slot_data_s)
    );

    assign in_ready      = in_ready_s;
    assign out_valid     = slot_valid_s;
    assign out_mask      = slot_data_s[N+ADDR_SIZE-1:ADDR_SIZE];
    assign out_base_addr = slot_data_s[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_nz_mask_builder.sv
// Directed self-checking bench for nz_mask_builder.
module tb_nz_mask_builder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_neuron;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mask;
    logic [15:0] out_base_addr;

    int checks;
    int errors;
    logic saw_stall;

    nz_mask_builder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_neuron     (in_neuron),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mask      (out_mask),
        .out_base_addr (out_base_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one neuron at a negedge, let it be accepted, return at next negedge.
    task automatic push(input logic [15:0] v, input logic last);
        in_valid  = 1'b1;
        in_neuron = v;
        in_last   = last;
        #1;
        if (in_ready !== 1'b1) saw_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] a);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mask !== 16'h0000 || out_base_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b mask=%h addr=%h, required 1 0 0000 0000",
                     in_ready, out_valid, out_mask, out_base_addr);
        end
    endtask

    task automatic test_single_brick();
        out_ready = 1'b1;
        do_start(16'h0100);
        for (int i = 0; i < 16; i++) begin
            push((i == 1) ? 16'd5 : ((i == 4) ? 16'd7 : 16'd0), 1'b0);
            if (i == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: out_valid=%b required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'h0012 || out_base_addr !== 16'h0100) begin
            errors++;
            $display("FAIL single_brick: valid=%b mask=%h addr=%h, required 1 0012 0100",
                     out_valid, out_mask, out_base_addr);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_start(16'h0100);
        saw_stall = 1'b0;
        for (int i = 0; i < 32; i++) begin
            push(((i % 3) == 0) ? 16'd0 : 16'(i + 1), 1'b0);
            if (i == 15) begin
                checks++;
                if (out_valid !== 1'b1 || out_mask !== 16'h6DB6 || out_base_addr !== 16'h0100) begin
                    errors++;
                    $display("FAIL b2b_first: valid=%b mask=%h addr=%h, required 1 6db6 0100",
                             out_valid, out_mask, out_base_addr);
                end
            end
            if (i == 31) begin
                checks++;
                if (out_valid !== 1'b1 || out_mask !== 16'hB6DB || out_base_addr !== 16'h0110) begin
                    errors++;
                    $display("FAIL b2b_second: valid=%b mask=%h addr=%h, required 1 b6db 0110",
                             out_valid, out_mask, out_base_addr);
                end
            end
        end
        checks++;
        if (saw_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_in_ready: stall seen=%b required 0", saw_stall);
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(16'h0001, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'hFFFF || out_base_addr !== 16'h0120) begin
            errors++;
            $display("FAIL bp_held: valid=%b mask=%h addr=%h, required 1 ffff 0120",
                     out_valid, out_mask, out_base_addr);
        end
        saw_stall = 1'b0;
        for (int j = 0; j < 15; j++) push(((j % 2) == 1) ? 16'h00F0 : 16'h0000, 1'b0);
        checks++;
        if (saw_stall !== 1'b0 || out_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL bp_partial: stall=%b mask=%h, required 0 ffff", saw_stall, out_mask);
        end
        in_valid  = 1'b1;
        in_neuron = 16'h8000;
        in_last   = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: in_ready=%b required 0", in_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_mask !== 16'hFFFF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall_hold: in_ready=%b valid=%b mask=%h, required 0 1 ffff",
                     in_ready, out_valid, out_mask);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'hAAAA || out_base_addr !== 16'h0130) begin
            errors++;
            $display("FAIL bp_second: valid=%b mask=%h addr=%h, required 1 aaaa 0130",
                     out_valid, out_mask, out_base_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_last();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(16'(i + 1), (i == 4));
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'h001F || out_base_addr !== 16'h0140) begin
            errors++;
            $display("FAIL last_short: valid=%b mask=%h addr=%h, required 1 001f 0140",
                     out_valid, out_mask, out_base_addr);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_neuron = 16'h0009;
        in_last   = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL last_stall: in_ready=%b required 0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_release: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'h0001 || out_base_addr !== 16'h0150) begin
            errors++;
            $display("FAIL last_single: valid=%b mask=%h addr=%h, required 1 0001 0150",
                     out_valid, out_mask, out_base_addr);
        end
        idle(1);
    endtask

    task automatic test_start_mid_brick();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(16'h0003, 1'b0);
        do_start(16'h0200);
        for (int i = 0; i < 16; i++) begin
            push((i == 0) ? 16'h0000 : 16'h0010, 1'b0);
            if (i == 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL start_discard: out_valid=%b required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'hFFFE || out_base_addr !== 16'h0200) begin
            errors++;
            $display("FAIL start_brick: valid=%b mask=%h addr=%h, required 1 fffe 0200",
                     out_valid, out_mask, out_base_addr);
        end
        idle(1);
    endtask

    task automatic test_wrap_and_reset();
        out_ready = 1'b1;
        do_start(16'hFFF0);
        for (int i = 0; i < 32; i++) begin
            push(16'h0001, 1'b0);
            if (i == 15) begin
                checks++;
                if (out_valid !== 1'b1 || out_mask !== 16'hFFFF || out_base_addr !== 16'hFFF0) begin
                    errors++;
                    $display("FAIL wrap_first: valid=%b mask=%h addr=%h, required 1 ffff fff0",
                             out_valid, out_mask, out_base_addr);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_base_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_second: valid=%b addr=%h, required 1 0000", out_valid, out_base_addr);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(16'h0001, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mask !== 16'h0000 || out_base_addr !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b valid=%b mask=%h addr=%h, required 1 0 0000 0000",
                     in_ready, out_valid, out_mask, out_base_addr);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push((i == 0) ? 16'h0000 : 16'h0001, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 16'hFFFE || out_base_addr !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset: valid=%b mask=%h addr=%h, required 1 fffe 0000",
                     out_valid, out_mask, out_base_addr);
        end
        idle(1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        saw_stall  = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 16'h0000;
        in_valid   = 1'b0;
        in_neuron  = 16'h0000;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single_brick();
        test_back_to_back();
        test_backpressure();
        test_last();
        test_start_mid_brick();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
